// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read mode, and level flags.
// Sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_FLAG_EN is defined.
module sync_fifo_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] count_o,
  input  logic             err_clr_i,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rdAcc;
  logic             wrAcc;

  assign count_o        = count_q;
  assign full_o         = (count_q == CNT_W'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty_o = (count_q <= CNT_W'(AE_LEVEL));

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign rdAcc = rd_en_i & ~empty_o;
  assign wrAcc = wr_en_i & (~full_o | rdAcc);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrAcc) begin
      wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
    end
    if (rdAcc) begin
      rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
    end
    if (wrAcc && !rdAcc) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wrAcc && rdAcc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wrAcc && !rst_i) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata_o  = empty_o ? '0 : mem_q[rdPtr_q];
      assign rvalid_o = ~empty_o;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q, rdata_d;
      logic             rvalid_q, rvalid_d;

      // Read data is held between pops rather than zeroed.
      always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rdAcc;
        if (rdAcc) begin
          rdata_d = mem_q[rdPtr_q];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error in the clearing cycle wins over the clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en_i && !wrAcc) begin
      overflow_d = 1'b1;
    end else if (err_clr_i) begin
      overflow_d = 1'b0;
    end
    if (rd_en_i && empty_o) begin
      underflow_d = 1'b1;
    end else if (err_clr_i) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  logic unusedErrClr;
  assign unusedErrClr = err_clr_i;
  assign overflow_o   = 1'b0;
  assign underflow_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one standard-mode and one FWFT instance, WIDTH=8 DEPTH=5 AF=4 AE=1.
// Error-flag expectations follow whether SYNC_FIFO_ERR_FLAG_EN is defined.
module tb_sync_fifo_ctrl;

`ifdef SYNC_FIFO_ERR_FLAG_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk;
  logic       rst, wrEn, rdEn, errClr;
  logic [7:0] wdata, rdata;
  logic       rvalid, full, empty, af, ae, ovf, udf;
  logic [2:0] count;

  logic       fRst, fWrEn, fRdEn, fErrClr;
  logic [7:0] fWdata, fRdata;
  logic       fRvalid, fFull, fEmpty, fAf, fAe, fOvf, fUdf;
  logic [2:0] fCount;

  int testsRun = 0;
  int testsFailed = 0;

  sync_fifo_ctrl #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) dutStd (
    .clk_i(clk), .rst_i(rst), .wdata_i(wdata), .wr_en_i(wrEn), .rd_en_i(rdEn),
    .rdata_o(rdata), .rvalid_o(rvalid), .full_o(full), .empty_o(empty),
    .almost_full_o(af), .almost_empty_o(ae), .count_o(count),
    .err_clr_i(errClr), .overflow_o(ovf), .underflow_o(udf)
  );

  sync_fifo_ctrl #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) dutFwft (
    .clk_i(clk), .rst_i(fRst), .wdata_i(fWdata), .wr_en_i(fWrEn), .rd_en_i(fRdEn),
    .rdata_o(fRdata), .rvalid_o(fRvalid), .full_o(fFull), .empty_o(fEmpty),
    .almost_full_o(fAf), .almost_empty_o(fAe), .count_o(fCount),
    .err_clr_i(fErrClr), .overflow_o(fOvf), .underflow_o(fUdf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re, input logic ec);
    wrEn = we; wdata = wd; rdEn = re; errClr = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic applyFwftStimulus(input logic we, input logic [7:0] wd, input logic re);
    fWrEn = we; fWdata = wd; fRdEn = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; errClr = 1'b0; wdata = '0;
    fRst = 1'b1; fWrEn = 1'b0; fRdEn = 1'b0; fErrClr = 1'b0; fWdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_ae", ae, 1);
    checkOutput("rst_af", af, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_udf", udf, 0);
    checkOutput("f_rst_rdata", fRdata, 0);
    checkOutput("f_rst_rvalid", fRvalid, 0);
    checkOutput("f_rst_empty", fEmpty, 1);
    rst = 1'b0;
    fRst = 1'b0;

    // Fill and drain
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      checkOutput($sformatf("fill_count%0d", i), count, i + 1);
      checkOutput($sformatf("fill_full%0d", i), full, (i == 4) ? 1 : 0);
      checkOutput($sformatf("fill_af%0d", i), af, (i + 1 >= 4) ? 1 : 0);
      checkOutput($sformatf("fill_ae%0d", i), ae, (i + 1 <= 1) ? 1 : 0);
      checkOutput($sformatf("fill_empty%0d", i), empty, 0);
      checkOutput($sformatf("fill_rvalid%0d", i), rvalid, 0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("drain_rdata%0d", i), rdata, 8'h10 + i);
      checkOutput($sformatf("drain_rvalid%0d", i), rvalid, 1);
      checkOutput($sformatf("drain_count%0d", i), count, 4 - i);
      checkOutput($sformatf("drain_af%0d", i), af, (4 - i >= 4) ? 1 : 0);
      checkOutput($sformatf("drain_ae%0d", i), ae, (4 - i <= 1) ? 1 : 0);
      checkOutput($sformatf("drain_full%0d", i), full, 0);
    end
    checkOutput("drain_empty", empty, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("idle_rvalid", rvalid, 0);
    checkOutput("idle_rdata_hold", rdata, 8'h14);
    checkOutput("idle_udf", udf, 0);

    // Wrap-around with simultaneous traffic at count 2
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
    checkOutput("wrap_pre_count", count, 2);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(8'h22 + k), 1'b1, 1'b0);
      checkOutput($sformatf("wrap_rdata%0d", k), rdata, 8'h20 + k);
      checkOutput($sformatf("wrap_rvalid%0d", k), rvalid, 1);
      checkOutput($sformatf("wrap_count%0d", k), count, 2);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("wrap_tail_rdata0", rdata, 8'h2A);
    checkOutput("wrap_tail_count0", count, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("wrap_tail_rdata1", rdata, 8'h2B);
    checkOutput("wrap_tail_count1", count, 0);
    checkOutput("wrap_tail_empty", empty, 1);

    // Simultaneous write and read while full
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    checkOutput("full2_count", count, 5);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("fullrw_rdata", rdata, 8'h30);
    checkOutput("fullrw_rvalid", rvalid, 1);
    checkOutput("fullrw_count", count, 5);
    checkOutput("fullrw_full", full, 1);
    checkOutput("fullrw_ovf", ovf, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("fullrw_drain%0d", i), rdata, (i == 4) ? 8'hAA : 8'h31 + i);
    end
    checkOutput("fullrw_empty", empty, 1);

    // Simultaneous write and read while empty
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("emptyrw_rvalid", rvalid, 0);
    checkOutput("emptyrw_count", count, 1);
    checkOutput("emptyrw_rdata_hold", rdata, 8'hAA);
    checkOutput("emptyrw_udf", udf, ERR);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("emptyrw_clr_udf", udf, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("emptyrw_read", rdata, 8'h77);
    checkOutput("emptyrw_count2", count, 0);

    // Overflow and underflow
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    checkOutput("ovf_pre", ovf, 0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    checkOutput("ovf_flag", ovf, ERR);
    checkOutput("ovf_count", count, 5);
    checkOutput("ovf_full", full, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("ovf_drain%0d", i), rdata, 8'h40 + i);
    end
    checkOutput("ovf_sticky", ovf, ERR);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_flag", udf, ERR);
    checkOutput("udf_rvalid", rvalid, 0);
    checkOutput("udf_count", count, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_ovf", ovf, 0);
    checkOutput("clr_udf", udf, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("setwins_udf", udf, ERR);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("setwins_clr", udf, 0);

    // Mid-operation reset
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("mid_udf_pre", udf, ERR);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("mid_pre_count", count, 3);
    checkOutput("mid_pre_rdata", rdata, 8'h50);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("mid_count", count, 0);
    checkOutput("mid_empty", empty, 1);
    checkOutput("mid_full", full, 0);
    checkOutput("mid_rdata", rdata, 0);
    checkOutput("mid_rvalid", rvalid, 0);
    checkOutput("mid_ovf", ovf, 0);
    checkOutput("mid_udf", udf, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("mid_post_rvalid", rvalid, 0);
    checkOutput("mid_post_count", count, 0);

    // First-word-fall-through
    applyFwftStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("f_first_rdata", fRdata, 8'h55);
    checkOutput("f_first_rvalid", fRvalid, 1);
    checkOutput("f_first_count", fCount, 1);
    applyFwftStimulus(1'b1, 8'h66, 1'b0);
    checkOutput("f_second_rdata", fRdata, 8'h55);
    checkOutput("f_second_count", fCount, 2);
    applyFwftStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("f_pop1_rdata", fRdata, 8'h66);
    checkOutput("f_pop1_count", fCount, 1);
    applyFwftStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("f_pop2_rdata", fRdata, 0);
    checkOutput("f_pop2_rvalid", fRvalid, 0);
    checkOutput("f_pop2_empty", fEmpty, 1);
    applyFwftStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("f_emptyrw_count", fCount, 1);
    checkOutput("f_emptyrw_rdata", fRdata, 8'h77);
    applyFwftStimulus(1'b1, 8'h78, 1'b1);
    checkOutput("f_rw_count", fCount, 1);
    checkOutput("f_rw_rdata", fRdata, 8'h78);
    for (int i = 0; i < 4; i++) applyFwftStimulus(1'b1, 8'(8'h79 + i), 1'b0);
    checkOutput("f_full", fFull, 1);
    checkOutput("f_full_rdata", fRdata, 8'h78);
    applyFwftStimulus(1'b1, 8'h7D, 1'b1);
    checkOutput("f_fullrw_count", fCount, 5);
    checkOutput("f_fullrw_rdata", fRdata, 8'h79);
    for (int i = 0; i < 5; i++) begin
      applyFwftStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("f_drain%0d", i), fRdata, (i == 4) ? 8'h00 : 8'h7A + i);
      checkOutput($sformatf("f_drain_rvalid%0d", i), fRvalid, (i == 4) ? 0 : 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
